// File: rtl/aes_dec_pkg.sv
// Shared types, tables and GF(2^8) helpers for the iterative AES decipher core.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    Aes128  = 2'b00,
    Aes192  = 2'b01,
    Aes256  = 2'b10,
    AesRsvd = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StKexp = 2'b01,
    StDec  = 2'b10
  } state_e;

  // Byte k of each table sits at bits [2047-8k -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [3:0] nk(input mode_e m);
    unique case (m)
      Aes192:  return 4'd6;
      Aes256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr(input mode_e m);
    unique case (m)
      Aes192:  return 4'd12;
      Aes256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    unique case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Zero the key bits the mode does not use so cache compares ignore them.
  function automatic logic [255:0] key_mask(input mode_e m, input logic [255:0] k);
    unique case (m)
      Aes128:  return {k[255:128], 128'h0};
      Aes192:  return {k[255:64], 64'h0};
      default: return k;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] i_state_in,
  input  logic [127:0] i_rk,
  input  logic         i_final_rnd,
  output logic [127:0] o_state_out
);

  logic [127:0] w_ark;
  logic [127:0] w_mix;

  // Row r of column c comes from column (c - r) mod 4; byte index is 4*col + row.
  always_comb begin
    w_ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_ark[127 - 8 * (4 * c + r) -: 8] =
            inv_sbox(i_state_in[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]) ^
            i_rk[127 - 8 * (4 * c + r) -: 8];
      end
    end
  end

  // InvMixColumns applied column by column.
  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[127 - 32 * c -: 32] = inv_mix_col(w_ark[127 - 32 * c -: 32]);
    end
  end

  assign o_state_out = i_final_rnd ? w_ark : w_mix;

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128/192/256 decipher: word-serial key expansion into a local
// round-key store with a one-entry schedule cache, then one inverse round per cycle.
module aes_dec_iter
  import aes_dec_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  input  logic [255:0] i_key,
  input  logic [127:0] i_data_in,
  output logic         o_ready,
  output logic [127:0] o_data_out,
  output logic         o_done,
  output logic         o_err
);

  state_e       r_fsm;
  state_e       w_fsm_nxt;
  mode_e        r_mode;
  logic [255:0] r_key;
  logic [127:0] r_data;
  logic [127:0] r_st;
  logic [127:0] r_dout;
  logic         r_cache_valid;
  logic         r_done;
  logic         r_err;
  logic [5:0]   r_i;
  logic [2:0]   r_pos;
  logic [3:0]   r_rci;
  logic [3:0]   r_round;
  logic [31:0]  r_w [60];
  // Last eight expanded words, newest in [31:0]; w[i-Nk] sits Nk words up.
  logic [255:0] r_win;

  mode_e        w_in_mode;
  logic         w_idle;
  logic         w_go;
  logic         w_bad;
  logic         w_hit;
  logic         w_last_kexp;
  logic         w_last_round;
  logic [255:0] w_mkey;
  logic [255:0] w_win_init;
  logic [3:0]   w_nk;
  logic [3:0]   w_nr;
  logic [31:0]  w_prev;
  logic [31:0]  w_old;
  logic [31:0]  w_temp;
  logic [31:0]  w_new;
  logic [5:0]   w_base;
  logic [127:0] w_rk;
  logic [127:0] w_rnd_out;

  assign w_in_mode    = mode_e'(i_mode);
  assign w_idle       = (r_fsm == StIdle);
  assign w_go         = i_start && w_idle && (w_in_mode != AesRsvd);
  assign w_bad        = i_start && w_idle && (w_in_mode == AesRsvd);
  assign w_mkey       = key_mask(w_in_mode, i_key);
  assign w_hit        = CACHE_EN && r_cache_valid && (w_mkey == r_key) && (w_in_mode == r_mode);
  assign w_nk         = nk(r_mode);
  assign w_nr         = nr(r_mode);
  assign w_last_kexp  = (r_i == {w_nr, 2'b11});
  assign w_last_round = (r_round == 4'd0);
  assign w_prev       = r_win[31:0];
  assign w_base       = {r_round, 2'b00};
  assign w_rk         = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};

  // Right-align the key words in the window and pick the w[i-Nk] tap.
  always_comb begin
    w_win_init = w_mkey;
    w_old      = r_win[255:224];
    unique case (w_in_mode)
      Aes128:  w_win_init = w_mkey >> 128;
      Aes192:  w_win_init = w_mkey >> 64;
      default: w_win_init = w_mkey;
    endcase
    unique case (r_mode)
      Aes128:  w_old = r_win[127:96];
      Aes192:  w_old = r_win[191:160];
      default: w_old = r_win[255:224];
    endcase
  end

  // Next key-schedule word; r_pos tracks i mod Nk.
  always_comb begin
    w_temp = w_prev;
    if (r_pos == 3'd0) begin
      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_rci), 24'h0};
    end else if ((r_mode == Aes256) && (r_pos == 3'd4)) begin
      w_temp = sub_word(w_prev);
    end
    w_new = w_old ^ w_temp;
  end

  aes_inv_round u_inv_round (
    .i_state_in  (r_st),
    .i_rk        (w_rk),
    .i_final_rnd (w_last_round),
    .o_state_out (w_rnd_out)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_fsm <= StIdle;
    else         r_fsm <= w_fsm_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      StIdle: if (w_go) w_fsm_nxt = w_hit ? StDec : StKexp;
      StKexp: if (w_last_kexp) w_fsm_nxt = StDec;
      StDec:  if (w_last_round) w_fsm_nxt = StIdle;
      default: w_fsm_nxt = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_ready    = (r_fsm == StIdle);
    o_done     = r_done;
    o_err      = r_err;
    o_data_out = r_dout;
  end

  // Request latch, expansion counters, cache flag and round datapath.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode        <= Aes128;
      r_key         <= '0;
      r_data        <= '0;
      r_st          <= '0;
      r_dout        <= '0;
      r_cache_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_i           <= '0;
      r_pos         <= '0;
      r_rci         <= '0;
      r_round       <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_bad;
      unique case (r_fsm)
        StIdle: begin
          if (w_go) begin
            r_data  <= i_data_in;
            r_mode  <= w_in_mode;
            r_key   <= w_mkey;
            r_round <= nr(w_in_mode);
            if (!w_hit) begin
              r_cache_valid <= 1'b0;
              r_i           <= {2'b00, nk(w_in_mode)};
              r_pos         <= 3'd0;
              r_rci         <= 4'd1;
            end
          end
        end
        StKexp: begin
          r_i   <= r_i + 6'd1;
          r_pos <= ({1'b0, r_pos} == w_nk - 4'd1) ? 3'd0 : r_pos + 3'd1;
          if (r_pos == 3'd0) r_rci <= r_rci + 4'd1;
          if (w_last_kexp) r_cache_valid <= 1'b1;
        end
        StDec: begin
          r_round <= r_round - 4'd1;
          if (r_round == w_nr) begin
            r_st <= r_data ^ w_rk;
          end else if (!w_last_round) begin
            r_st <= w_rnd_out;
          end else begin
            r_dout <= w_rnd_out;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key store and sliding window; deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (w_go && !w_hit) begin
      r_win <= w_win_init;
      for (int k = 0; k < 8; k++) begin
        r_w[k] <= w_mkey[255 - 32 * k -: 32];
      end
    end else if (r_fsm == StKexp) begin
      r_win    <= {r_win[223:0], w_new};
      r_w[r_i] <= w_new;
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter using FIPS-197 known-answer vectors.
module tb_aes_dec_iter;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] data_out;
  logic         done;
  logic         err;

  int total;
  int bad;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K128J  = {128'h000102030405060708090a0b0c0d0e0f,
                                     128'hdeadbeef0badf00d123456789abcdef0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                     64'hcafef00d55aa55aa};
  localparam logic [255:0] K256   =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  aes_dec_iter #(
    .CACHE_EN (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_mode     (mode),
    .i_key      (key),
    .i_data_in  (data_in),
    .o_ready    (ready),
    .o_data_out (data_out),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Accept one block, scramble inputs, and measure edges until done.
  task automatic run_vec(input string nm, input logic [1:0] m, input logic [255:0] k,
                         input logic [127:0] ct, input logic [127:0] pt, input int lat);
    int n;
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    key     = k;
    data_in = ct;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = m ^ 2'b01;
    key     = ~k;
    data_in = ~ct;
    chk({nm, " busy"}, {255'h0, ready}, 256'h0);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " plaintext"}, {128'h0, data_out}, {128'h0, pt});
    chk({nm, " ready at done"}, {255'h0, ready}, 256'h1);
  endtask

  initial begin
    int n;
    int dones;
    int errs;
    int first;
    int second;
    int hold_bad;

    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    key     = '0;
    data_in = '0;

    vecs[0] = '{mode: 2'b00, key: K128,  ct: CT128, pt: PT, lat: 51};
    vecs[1] = '{mode: 2'b00, key: K128J, ct: CT128, pt: PT, lat: 11};
    vecs[2] = '{mode: 2'b01, key: K192,  ct: CT192, pt: PT, lat: 59};
    vecs[3] = '{mode: 2'b10, key: K256,  ct: CT256, pt: PT, lat: 67};
    vecs[4] = '{mode: 2'b00, key: K128,  ct: CT128, pt: PT, lat: 51};
    vecs[5] = '{mode: 2'b00, key: K128,  ct: CT128, pt: PT, lat: 11};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {255'h0, ready}, 256'h1);
    chk("reset done", {255'h0, done}, 256'h0);
    chk("reset err", {255'h0, err}, 256'h0);
    chk("reset data_out", {128'h0, data_out}, 256'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].mode, vecs[v].key, vecs[v].ct, vecs[v].pt,
              vecs[v].lat);
    end

    // Reserved mode: err pulse, no acceptance, cache left alone.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b11;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rsvd err", {255'h0, err}, 256'h1);
    chk("rsvd ready", {255'h0, ready}, 256'h1);
    chk("rsvd done", {255'h0, done}, 256'h0);
    @(posedge clk);
    #1;
    chk("rsvd err pulse", {255'h0, err}, 256'h0);
    run_vec("after rsvd", 2'b00, K128, CT128, PT, 11);

    // Start held high through done: back-to-back accept on the done cycle.
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b00;
    key     = K128;
    data_in = CT128;
    @(posedge clk);
    #1;
    n      = 0;
    dones  = 0;
    first  = -1;
    second = -1;
    while (n < 80 && dones < 2) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dones++;
        if (first < 0) first = n;
        else begin
          second = n;
          start  = 1'b0;
        end
        chk("held plaintext", {128'h0, data_out}, {128'h0, PT});
      end
    end
    start = 1'b0;
    chk("held first done", first, 11);
    chk("held second done", second, 23);
    repeat (14) @(posedge clk);

    // Start pulsed while deciphering: ignored, one done, output held.
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b00;
    key     = K128;
    data_in = CT128;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = 0;
    dones    = 0;
    errs     = 0;
    first    = -1;
    hold_bad = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) begin
        start   = 1'b1;
        mode    = 2'b11;
        data_in = 128'h0123456789abcdef0123456789abcdef;
      end else if (n == 6) begin
        start   = 1'b1;
        mode    = 2'b00;
        key     = K256;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first < 0) first = n;
      end
      if (err) errs++;
      if (first >= 0 && data_out !== PT) hold_bad++;
    end
    start = 1'b0;
    chk("busy start done count", dones, 1);
    chk("busy start done edge", first, 11);
    chk("busy start no err", errs, 0);
    chk("busy start hold", hold_bad, 0);

    // Reset at edge 20 of a 256-bit expansion, then re-expand the same key.
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b10;
    key     = K256;
    data_in = CT256;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("mid busy", {255'h0, ready}, 256'h0);
    reset = 1'b1;
    #1;
    chk("abort ready", {255'h0, ready}, 256'h1);
    chk("abort done", {255'h0, done}, 256'h0);
    chk("abort err", {255'h0, err}, 256'h0);
    chk("abort data_out", {128'h0, data_out}, 256'h0);
    @(negedge clk);
    reset = 1'b0;
    run_vec("after abort", 2'b10, K256, CT256, PT, 67);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_iter.md
Name: aes_dec_iter

Overview:
Iterative AES decipher core; the inverse direction of the pipelined encipher path, with the same mode encoding and key-bus layout. Accepts a ciphertext block and a 128/192/256-bit key. Expands the key word-serially into a local round-key store, then applies one inverse round per cycle. Caches the expanded schedule so back-to-back blocks under the same key skip expansion.

Parameters:
CACHE_EN, 1, 1 = reuse the stored schedule when the key and mode match the last expansion; 0 = always expand.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  request; accepted at a rising edge where start && ready && mode!=2'b11
mode  in  2  00=AES-128 (Nk=4, Nr=10), 01=AES-192 (Nk=6, Nr=12), 10=AES-256 (Nk=8, Nr=14), 11=reserved
key  in  256  MSB-aligned key: 128-bit uses key[255:128]; 192-bit uses key[255:64]; word0=key[255:224]; unused bits ignored
data_in  in  128  ciphertext; byte0=data_in[127:120]
ready  out  1  high exactly when FSM is IDLE
data_out  out  128  plaintext; valid from done onward, held until next accepted start
done  out  1  one-cycle pulse, plaintext valid
err  out  1  one-cycle pulse when start && ready && mode==2'b11

Behaviour:
- Reset (async): state=IDLE, ready=1, data_out=0, done=0, err=0, cache_valid=0. Round-key store is not cleared.
- Reset asserted mid-operation aborts the block. No done is produced.
- FSM states: IDLE, KEXP, DEC.
- Accept edge: latch data_in, mode and the masked key.
  - Hit (CACHE_EN && cache_valid && key and mode equal to cached values): go to DEC with r=Nr.
  - Miss: write words w[0..Nk-1] and the 8-word sliding window from the key, clear cache_valid, go to KEXP with i=Nk.
- KEXP: one word per edge, for i = Nk .. 4Nr+3.
  - temp = w[i-1].
  - If i%Nk==0: temp = SubWord(RotWord(temp)) ^ Rcon[i/Nk].
  - Else if Nk==8 and i%Nk==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - Number of KEXP edges E = 4(Nr+1)-Nk: 40, 46 or 52.
  - On the last edge: set cache_valid, go to DEC with r=Nr.
- DEC: one edge per r, with rk[r] = w[4r..4r+3].
  - r=Nr: state = data ^ rk[Nr].
  - Nr-1 >= r >= 1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - r=0: data_out = InvSubBytes(InvShiftRows(state)) ^ rk[0]; done=1 for one cycle; go to IDLE.
- Latency: done is high in the cycle after accept-edge + (Nr+1) edges on a hit; add E edges on a miss.
  - Hit: 11 / 13 / 15 edges.
  - Miss: 51 / 59 / 67 edges.
- ready=1 in the same cycle as done, so a new start may be accepted on the very next edge.
- start while busy: ignored, no err, no queuing.
- mode==11 at a ready edge: not accepted, state stays IDLE, err pulse. The cache is untouched.
- Cache compare uses only the mode-relevant key bits, so differing unused bits still hit.
- Inputs are don't-care except at the accept edge.

Decomposition:
- Package aes_dec_pkg holds:
  - mode typedef (AES128/192/256/RSVD);
  - functions nk(mode) and nr(mode);
  - Rcon table (1..10);
  - forward S-box (for SubWord) and inverse S-box;
  - xtime and gf_mul helpers;
  - FSM state enum.
- One combinational sub-module, aes_inv_round (state_in, rk, final_rnd -> state_out). It performs InvShiftRows, InvSubBytes, AddRoundKey, and InvMixColumns unless final_rnd.
- Key expansion, cache and FSM live in the top module.

Test Plan:
- FIPS-197 AES-128: key 000102…0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff; done 51 edges after accept.
- Repeat the same block and key back-to-back, start held through done -> second done 11 edges after the second accept, same plaintext (cache hit).
- AES-192: key 000102…17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233…eeff in 59 edges. Then AES-256: key 000102…1f, ct 8ea2b7ca516745bfeafc49904b496089 -> 00112233…eeff in 67 edges (mode change forces expansion).
- mode=11 with start=1 -> err high for one cycle, ready stays 1, no done. Then a 128-bit hit request still completes in 11 edges.
- Assert reset at edge 20 of a miss expansion -> done/err/data_out=0 immediately, ready=1. Next start with the same key re-expands (51 edges) and yields the correct plaintext.
- start pulsed during DEC -> ignored. Exactly one done, and data_out is held constant until the next accept.
